// File: rtl/pipe_defs.sv
// Shared decode definitions: opcodes, ALUOp encodings and the control bundle.
package pipe_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } aluop_t;

  // Field order is the order the ID/EX control bits are packed in.
  typedef struct packed {
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    aluop_t aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(8'h00);

  // Control bundle for one opcode; unknown opcodes and j carry no control.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NONE;
    case (op)
      OP_RTYPE: begin c.regwrite = 1'b1; c.aluop = ALU_FUNCT; end
      OP_LW:    begin c.alusrc = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; c.memread = 1'b1; end
      OP_SW:    begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
      OP_BEQ:   begin c.branch = 1'b1; c.aluop = ALU_SUB; end
      OP_ADDI:  begin c.alusrc = 1'b1; c.regwrite = 1'b1; end
      OP_SLTI, OP_ANDI, OP_ORI: begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = ALU_IMM; end
      default:  c = CTRL_NONE;
    endcase
    return c;
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/reg_file_bp.sv
// Register file with two read ports; a same-cycle write-back is forwarded to the readers.
module reg_file_bp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int REG_AW = ($clog2(NREG) < 5) ? 5 : $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] wn,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;

  assign wr_ok = we && (wn != '0) && (int'(wn) < NREG);

  // Write port: register 0 and out-of-range indices are never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wn] <= wd;
    end
  end

  // Read ports: x0 reads zero, a matching write-back wins over the stored value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) begin
      if (wr_ok && wn == ra1)    rd1 = wd;
      else if (int'(ra1) < NREG) rd1 = regs[ra1];
    end
    if (ra2 != '0) begin
      if (wr_ok && wn == ra2)    rd2 = wd;
      else if (int'(ra2) < NREG) rd2 = regs[ra2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decode, load-use hazard detection, jump resolution and ID/EX register.
module decode_stage
  import pipe_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16,
  localparam int REG_AW = ($clog2(NREG) < 5) ? 5 : $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [31:0]       if_instr,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wn,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              ex_flush,
  output logic              id_stall,
  output logic              id_redirect,
  output logic [DATA_W-1:0] id_jump_addr,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [REG_AW-1:0] ex_wn,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic              illegal_instr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd, dest;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_ext, rd1, rd2;
  ctrl_t             ctrl, ex_ctrl;
  logic              legal, uses_rt, load_bubble;

  assign opcode  = if_instr[31:26];
  assign rs      = REG_AW'(if_instr[25:21]);
  assign rt      = REG_AW'(if_instr[20:16]);
  assign rd      = REG_AW'(if_instr[15:11]);
  assign imm16   = if_instr[15:0];
  assign ctrl    = decode_ctrl(opcode);
  assign legal   = op_legal(opcode);
  assign uses_rt = op_uses_rt(opcode);
  assign dest    = (opcode == OP_RTYPE) ? rd : rt;
  assign imm_ext = (opcode == OP_ANDI || opcode == OP_ORI) ?
                   {{(DATA_W-16){1'b0}}, imm16} : {{(DATA_W-16){imm16[15]}}, imm16};

  reg_file_bp #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk(clk), .rst(rst),
    .we(wb_we), .wn(wb_wn), .wd(wb_wd),
    .ra1(rs), .ra2(rt),
    .rd1(rd1), .rd2(rd2)
  );

  // A load in EX whose destination feeds this instruction holds IF/ID; a flush overrides it.
  assign id_stall = !ex_flush && if_valid && ex_valid && ex_memread && (ex_wn != '0) &&
                    ((ex_wn == rs) || (uses_rt && ex_wn == rt));

  assign id_jump_addr = {if_pc[DATA_W-1:28], if_instr[25:0], 2'b00};
  assign id_redirect  = if_valid && (opcode == OP_J) && !id_stall;

  assign load_bubble = ex_flush || id_stall || !if_valid || !legal;

  // ID/EX register: data always follows ID, validity and control are cleared for bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_shamt      <= '0;
      ex_wn         <= '0;
      ex_ctrl       <= CTRL_NONE;
      illegal_instr <= 1'b0;
    end else begin
      ex_valid      <= !load_bubble;
      ex_pc         <= if_pc;
      ex_rd1        <= rd1;
      ex_rd2        <= rd2;
      ex_imm        <= imm_ext;
      ex_shamt      <= if_instr[10:6];
      ex_wn         <= dest;
      ex_ctrl       <= load_bubble ? CTRL_NONE : ctrl;
      illegal_instr <= !ex_flush && !id_stall && if_valid && !legal;
    end
  end

  // Count stalled cycles, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            stall_cnt <= '0;
    else if (id_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width of register data, PC and immediate outputs.
REQ-002 Parameter NREG, default 32: register count; REG_AW = clog2(NREG), minimum 5; register indices are rs/rt/rd zero-extended or truncated to REG_AW.
REQ-003 Parameter CNT_W, default 16: width of stall-cycle counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 if_valid in 1, if_pc in DATA_W, if_instr in 32: IF/ID register contents.
REQ-007 wb_we in 1, wb_wn in REG_AW, wb_wd in DATA_W: write-back port.
REQ-008 ex_flush in 1: branch mispredict from EX; squash instruction entering ID/EX.
REQ-009 id_stall out 1: IF holds PC and IF/ID this cycle.
REQ-010 id_redirect out 1, id_jump_addr out DATA_W: jump resolved in ID (combinational).
REQ-011 ex_valid out 1, ex_pc, ex_rd1, ex_rd2, ex_imm out DATA_W, ex_shamt out 5, ex_wn out REG_AW: ID/EX register.
REQ-012 ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch out 1 each; ex_aluop out 2: ID/EX control.
REQ-013 illegal_instr out 1: registered one-cycle pulse; stall_cnt out CNT_W.

Function
REQ-014 Decode opcodes R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D; RegDst = rd for R-type, rt otherwise.
REQ-015 ALUOp: lw/sw/addi 00, beq 01, R-type 10, slti/andi/ori 11.
REQ-016 Immediate sign-extended to DATA_W except andi/ori, which zero-extend.
REQ-017 Jump address = {if_pc[DATA_W-1:28], instr[25:0], 2'b00}; id_redirect = if_valid & opcode==j & !id_stall.
REQ-018 Register reads bypass write-back: if wb_we and wb_wn equals read index (non-zero), read returns wb_wd in the same cycle.
REQ-019 Register 0 always reads 0; writes to it are ignored.
REQ-020 Load-use hazard: id_stall = if_valid & ex_valid & ex_memread & ex_wn!=0 & (ex_wn==rs | (ex_wn==rt & instr uses rt: R-type, sw, beq)).
REQ-021 On stall, next edge loads a bubble: ex_valid=0, all ex_ control bits 0; data fields don't-care.
REQ-022 ex_flush has priority: next edge loads bubble regardless of stall or if_valid; id_stall is forced 0 while ex_flush=1.
REQ-023 Otherwise ID/EX loads decoded instruction, ex_valid = if_valid; invalid input loads all control bits 0.
REQ-024 j loads ex_valid=1 with all control bits 0 (no writeback).
REQ-025 Unknown opcode with if_valid: bubble loaded, illegal_instr=1 for exactly one cycle.
REQ-026 stall_cnt increments once per cycle id_stall=1; saturates at all-ones, no wrap.
REQ-027 Latency: instruction valid in IF/ID at edge N appears on ex_ outputs after edge N+1 unless stalled/flushed.

Reset
REQ-028 While rst=0: all ex_ outputs, illegal_instr, stall_cnt and every register-file entry are 0 immediately (asynchronous).
REQ-029 Reset mid-stall clears state; first edge after release processes the current IF/ID contents normally.

Structure
REQ-030 Opcode constants, ALUOp encodings and control-bundle field order shall live in shared package pipe_defs.
REQ-031 Register file with write bypass shall be sub-module reg_file_bp (params DATA_W, NREG); hazard, decode and ID/EX register in the top.

Verification
REQ-032 Write x5=0x1234 via WB while decoding add x6,x5,x0 same cycle -> ex_rd1=0x1234 next edge.
REQ-033 lw x3 in ID/EX, then add x4,x3,x1 in ID -> id_stall=1 one cycle, bubble (ex_valid=0), add issues next cycle, stall_cnt=1.
REQ-034 lw x0 followed by consumer of x0 -> no stall.
REQ-035 ex_flush=1 concurrent with load-use stall -> id_stall=0, bubble loaded.
REQ-036 if_pc=0x40000000, j 0x0000010 -> id_redirect=1, id_jump_addr=0x40000040; ori with imm 0x8000 -> ex_imm=0x00008000.
REQ-037 Opcode 0x3F -> illegal_instr one-cycle pulse, ex_valid=0; rst asserted mid-stream -> all outputs 0 without clock.
